// File: rtl/tinycore_ram.sv
// tinycore_ram: single-port word-addressed data memory answering the tinyCore request interface.
// Optional out-of-range detection is enabled with the TINYCORE_RAM_BOUNDS_CHECK_EN macro.
module tinycore_ram #(
  parameter int DATA_SZ     = 16,
  parameter int ADDR_SZ     = 16,
  parameter int RAM_SZ      = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ram_req,
  input  logic               we,
  input  logic [ADDR_SZ-1:0] ram_addr,
  input  logic [DATA_SZ-1:0] ram_data_i,
  output logic [DATA_SZ-1:0] ram_data_o,
  output logic               ram_ack,
  output logic               ram_err
);

  localparam int IDX_W = $clog2(RAM_SZ);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ACK
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         wcnt_q, wcnt_d;
  logic               we_q;
  logic [IDX_W-1:0]   idx_q;
  logic [DATA_SZ-1:0] wdata_q;
  logic [DATA_SZ-1:0] rdata_q, rdata_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic               capture;
  logic               doAccess;
  logic               oorAccess;
  logic               memWe;

  logic [DATA_SZ-1:0] mem [RAM_SZ];

  assign capture  = (state_q == IDLE) && ram_req;
  assign doAccess = (state_q == BUSY) && (wcnt_q == 4'd0);

`ifdef TINYCORE_RAM_BOUNDS_CHECK_EN
  // The range flag is resolved at capture so the access edge only needs one bit.
  logic oor_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oor_q <= 1'b0;
    end else if (capture) begin
      oor_q <= (32'(ram_addr) >= RAM_SZ);
    end
  end

  assign oorAccess = oor_q;
`else
  if (IDX_W < ADDR_SZ) begin : g_wrap
    logic unusedUpperAddr;
    assign unusedUpperAddr = ^ram_addr[ADDR_SZ-1:IDX_W];
  end
  assign oorAccess = 1'b0;
`endif

  assign memWe = doAccess && we_q && !oorAccess;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: begin
        if (ram_req) begin
          state_d = BUSY;
          wcnt_d  = 4'(WAIT_STATES);
        end
      end
      BUSY: begin
        if (wcnt_q == 4'd0) begin
          state_d = ACK;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    ack_d   = doAccess;
    err_d   = doAccess && oorAccess;
    if (doAccess && !we_q) begin
      rdata_d = oorAccess ? '0 : mem[idx_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q  <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      if (capture) begin
        we_q    <= we;
        idx_q   <= ram_addr[IDX_W-1:0];
        wdata_q <= ram_data_i;
      end
    end
  end

  // Storage is deliberately left out of reset; only committed writes touch it.
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign ram_data_o = rdata_q;
  assign ram_ack    = ack_q;
  assign ram_err    = err_q;

endmodule

// File: tb/tb_tinycore_ram.sv
// Self-checking bench for tinycore_ram: three instances (0, 3 and 5 wait states) with a
// scoreboard per instance; expectations follow TINYCORE_RAM_BOUNDS_CHECK_EN when defined.
module tb_tinycore_ram;

  typedef struct {
    int          cyc;
    logic [15:0] data;
    logic        err;
  } expT;

`ifdef TINYCORE_RAM_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst   [3];
  logic        req   [3];
  logic        we    [3];
  logic [15:0] addr  [3];
  logic [15:0] wdata [3];
  logic [15:0] rdata [3];
  logic        ack   [3];
  logic        err   [3];

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  expT sb0[$];
  expT sb1[$];
  expT sb2[$];

  tinycore_ram #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst[0]), .ram_req(req[0]), .we(we[0]), .ram_addr(addr[0]),
    .ram_data_i(wdata[0]), .ram_data_o(rdata[0]), .ram_ack(ack[0]), .ram_err(err[0])
  );

  tinycore_ram #(.WAIT_STATES(3)) dut1 (
    .clk(clk), .rst(rst[1]), .ram_req(req[1]), .we(we[1]), .ram_addr(addr[1]),
    .ram_data_i(wdata[1]), .ram_data_o(rdata[1]), .ram_ack(ack[1]), .ram_err(err[1])
  );

  tinycore_ram #(.WAIT_STATES(5)) dut2 (
    .clk(clk), .rst(rst[2]), .ram_req(req[2]), .we(we[2]), .ram_addr(addr[2]),
    .ram_data_i(wdata[2]), .ram_data_o(rdata[2]), .ram_ack(ack[2]), .ram_err(err[2])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wsOf(int i);
    case (i)
      0:       return 0;
      1:       return 3;
      default: return 5;
    endcase
  endfunction

  task automatic cmp(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic pushExp(int i, int c, logic [15:0] d, logic e);
    expT x;
    x.cyc  = c;
    x.data = d;
    x.err  = e;
    case (i)
      0:       sb0.push_back(x);
      1:       sb1.push_back(x);
      default: sb2.push_back(x);
    endcase
  endtask

  // Pops the oldest expectation of an instance and compares timing, data and error flag.
  task automatic checkOutput(int i);
    expT x;
    bit  have;
    have = 1'b0;
    case (i)
      0:       if (sb0.size() > 0) begin x = sb0.pop_front(); have = 1'b1; end
      1:       if (sb1.size() > 0) begin x = sb1.pop_front(); have = 1'b1; end
      default: if (sb2.size() > 0) begin x = sb2.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpectedAck inst%0d got ack at cycle %0d want no ack", i, cyc);
    end else begin
      cmp($sformatf("ackCycle inst%0d", i), 32'(cyc), 32'(x.cyc));
      cmp($sformatf("readData inst%0d cyc%0d", i, cyc), 32'(rdata[i]), 32'(x.data));
      cmp($sformatf("errFlag inst%0d cyc%0d", i, cyc), 32'(err[i]), 32'(x.err));
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ack[i] === 1'b1) checkOutput(i);
    end
  end

  task automatic waitAck(int i);
    int n;
    n = 0;
    while (ack[i] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("[TB] FAIL ackTimeout inst%0d got no ack want ack within 40 cycles", i);
    end
    @(negedge clk);
  endtask

  // Issues one request in the current (IDLE) cycle and returns in the IDLE cycle after ACK.
  task automatic applyStimulus(int i, logic wr, logic [15:0] a, logic [15:0] d,
                               logic [15:0] expData, logic expErr);
    req[i]   = 1'b1;
    we[i]    = wr;
    addr[i]  = a;
    wdata[i] = d;
    pushExp(i, cyc + 2 + wsOf(i), expData, expErr);
    @(negedge clk);
    req[i]   = 1'b0;
    wdata[i] = 16'h0000;
    waitAck(i);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i]   = 1'b1;
      req[i]   = 1'b0;
      we[i]    = 1'b0;
      addr[i]  = 16'h0000;
      wdata[i] = 16'h0000;
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      cmp($sformatf("resetData inst%0d", i), 32'(rdata[i]), 32'h0);
      cmp($sformatf("resetAck inst%0d", i), 32'(ack[i]), 32'h0);
      cmp($sformatf("resetErr inst%0d", i), 32'(err[i]), 32'h0);
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    @(negedge clk);

    // Zero wait states: basic write/read, then the bounds/wrap sequence.
    applyStimulus(0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0);
    applyStimulus(0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);
    applyStimulus(0, 1'b1, 16'h0000, 16'h7777, 16'hBEEF, 1'b0);
    applyStimulus(0, 1'b1, 16'h0003, 16'h0303, 16'hBEEF, 1'b0);
    applyStimulus(0, 1'b1, 16'h0400, 16'h1234, 16'hBEEF, BC);
    applyStimulus(0, 1'b0, 16'h0000, 16'h0000, BC ? 16'h7777 : 16'h1234, 1'b0);
    applyStimulus(0, 1'b0, 16'h0400, 16'h0000, BC ? 16'h0000 : 16'h1234, BC);
    applyStimulus(0, 1'b1, 16'h0403, 16'h5A5A, BC ? 16'h0000 : 16'h1234, BC);
    applyStimulus(0, 1'b0, 16'h0003, 16'h0000, BC ? 16'h0303 : 16'h5A5A, 1'b0);
    applyStimulus(0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);
    applyStimulus(0, 1'b0, 16'h0000, 16'h0000, BC ? 16'h7777 : 16'h1234, 1'b0);
    applyStimulus(0, 1'b0, 16'h0003, 16'h0000, BC ? 16'h0303 : 16'h5A5A, 1'b0);

    // Three wait states with ram_req held through ACK: the re-request lands in IDLE.
    applyStimulus(1, 1'b1, 16'h00C0, 16'h3C3C, 16'h0000, 1'b0);
    begin
      int c0;
      c0       = cyc;
      req[1]   = 1'b1;
      we[1]    = 1'b0;
      addr[1]  = 16'h00C0;
      pushExp(1, c0 + 5, 16'h3C3C, 1'b0);
      pushExp(1, c0 + 11, 16'h3C3C, 1'b0);
      repeat (7) @(negedge clk);
      req[1] = 1'b0;
      waitAck(1);
    end

    // Five wait states: reset lands in BUSY with two waits left and drops the write.
    applyStimulus(2, 1'b1, 16'h0020, 16'h1111, 16'h0000, 1'b0);
    applyStimulus(2, 1'b0, 16'h0020, 16'h0000, 16'h1111, 1'b0);
    req[2]   = 1'b1;
    we[2]    = 1'b1;
    addr[2]  = 16'h0020;
    wdata[2] = 16'hAAAA;
    @(negedge clk);
    req[2] = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst[2] = 1'b1;
    #1;
    cmp("asyncResetData inst2", 32'(rdata[2]), 32'h0);
    cmp("asyncResetAck inst2", 32'(ack[2]), 32'h0);
    cmp("asyncResetErr inst2", 32'(err[2]), 32'h0);
    @(negedge clk);
    rst[2] = 1'b0;
    applyStimulus(2, 1'b0, 16'h0020, 16'h0000, 16'h1111, 1'b0);

    repeat (5) @(negedge clk);
    cmp("pendingExp inst0", 32'(sb0.size()), 32'h0);
    cmp("pendingExp inst1", 32'(sb1.size()), 32'h0);
    cmp("pendingExp inst2", 32'(sb2.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tinycore_ram.md
# tinycore_ram

Single-port 16-bit data memory that answers the tinyCore memory-request interface. The core drives address, write data and write enable. This block services each request after a configurable number of wait states and returns read data with a one-cycle acknowledge. It sits between the core's load/store unit and on-chip storage, and is the responder the core testbench instantiates as its RAM model.

## Interface
- `DATA_SZ`, 16, data word width.
- `ADDR_SZ`, 16, address width (word addressed).
- `RAM_SZ`, 1024, number of words; power of two, ≤ 2**ADDR_SZ.
- `WAIT_STATES`, 0, extra cycles inserted before each access; range 0..15.
- `clk`  in  1  system clock, rising-edge active.
- `rst`  in  1  reset, asynchronous, active-high.
- `ram_req`  in  1  request strobe; sampled only in IDLE.
- `we`  in  1  1 = write, 0 = read; sampled with `ram_req`.
- `ram_addr`  in  ADDR_SZ  word address; sampled with `ram_req`.
- `ram_data_i`  in  DATA_SZ  write data; sampled with `ram_req`.
- `ram_data_o`  out  DATA_SZ  read data; valid when `ram_ack`=1 on a read; holds until the next read completes.
- `ram_ack`  out  1  one-cycle completion pulse.
- `ram_err`  out  1  out-of-range flag; valid with `ram_ack`.

## Operation
- Storage: RAM_SZ x DATA_SZ array. Contents are not cleared by reset.
- FSM states: IDLE, BUSY, ACK.
  - IDLE: on a clock edge with `ram_req`=1, latch `we`, `ram_addr` and `ram_data_i`, load `wcnt`=WAIT_STATES, then go to BUSY.
  - BUSY: while `wcnt`≠0, decrement it each edge. On the edge where `wcnt`=0:
    - Perform the access: a write updates the array; a read loads `ram_data_o` from the array.
    - Set `ram_ack`=1 and `ram_err` per the bounds rule, then go to ACK.
  - ACK: lasts exactly one cycle. `ram_req` is ignored. Next edge clears `ram_ack`/`ram_err` and returns to IDLE.
- Requester handshake: deassert `ram_req` in the ACK cycle. If `ram_req` is still high in the following IDLE cycle, it is a new request.
- Input changes while in BUSY or ACK have no effect, because the request was latched in IDLE.
- Writes never change `ram_data_o`.
- Address decode: index = `ram_addr`[log2(RAM_SZ)-1:0]. The out-of-range handling is set by the Configuration section.
- Reset mid-operation forces IDLE immediately.
  - A pending access is dropped; the array is modified only if the write edge has already occurred.
  - Outputs take their reset values.

## Timing
- Reset values: `ram_data_o`=0, `ram_ack`=0, `ram_err`=0, state=IDLE, `wcnt`=0.
- A request is captured at edge N.
  - `ram_ack` is high for the one cycle following edge N+1+WAIT_STATES.
  - A write becomes visible in the array at that same edge.
- Latency with WAIT_STATES=0: `ram_ack` appears one cycle after the capture edge.
- Maximum throughput: one request per 3+WAIT_STATES cycles (IDLE capture, BUSY, ACK).
- A read of address A issued in the IDLE cycle right after the ACK of a write to A returns the new data. There is no read-during-write hazard.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- Macro: `TINYCORE_RAM_BOUNDS_CHECK_EN`.
- Defined:
  - `ram_addr` ≥ RAM_SZ sets `ram_err`=1 together with `ram_ack`.
  - An out-of-range write is suppressed.
  - An out-of-range read loads `ram_data_o`=0.
  - Timing is unchanged.
- Undefined:
  - The address wraps modulo RAM_SZ; the upper bits are ignored.
  - `ram_err` is tied to 0.

## Test plan
- WAIT_STATES=0:
  - Write 0xBEEF to 0x0010; `ram_ack` pulses one cycle after the capture edge and `ram_data_o` stays 0.
  - Read 0x0010; `ram_data_o`=0xBEEF with `ram_ack`.
- WAIT_STATES=3: read request captured at edge N -> `ram_ack` high only in the cycle after edge N+4; `ram_req` held high through ACK is not re-accepted until the IDLE cycle.
- Macro defined:
  - Write 0x1234 to 0x0400 -> `ram_ack`=1, `ram_err`=1.
  - Then read 0x0000 -> previous contents intact, `ram_err`=0.
  - Then read 0x0400 -> `ram_data_o`=0, `ram_err`=1.
- Macro undefined:
  - Write 0x5A5A to 0x0403; a read of 0x0003 returns 0x5A5A.
  - `ram_err` stays 0 throughout.
- WAIT_STATES=5: write 0xAAAA to 0x0020 over old value 0x1111, with `rst` asserted in BUSY while `wcnt`=2.
  - Outputs go to 0 asynchronously.
  - A later read of 0x0020 returns 0x1111.
  - The FSM accepts a request in the first cycle after `rst` deasserts.
- Back-to-back: three consecutive reads of different addresses, each issued in the IDLE cycle after the previous ACK -> `ram_ack` every 3 cycles with correct data each time.
